// File: rtl/exemem_lsu_reg_if.sv
// Data-side SRAM-like bus between the EXE/MEM load/store master and memory.
// The master drives the request fields; the slave answers with addr_ok/data_ok/rdata.
interface exemem_lsu_reg_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic                  data_req;
   logic                  data_wr;
   logic [1:0]            data_size;
   logic [ADDR_W-1:0]     data_addr;
   logic [DATA_W-1:0]     data_wdata;
   logic [DATA_W/8-1:0]   data_wstrb;
   logic [DATA_W-1:0]     data_rdata;
   logic                  data_addr_ok;
   logic                  data_data_ok;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
      input  data_rdata, data_addr_ok, data_data_ok
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
      output data_rdata, data_addr_ok, data_data_ok
   );
endinterface

// File: rtl/exemem_lsu_reg.sv
// EXE/MEM pipeline register with an integrated single-outstanding load/store
// bus master. Captures an opaque payload, issues one data request per aligned
// memory op, aligns/extends load data, and drains a bus-accepted request
// across a flush so the bus never sees an orphaned response.

// One byte lane of the store path: byte enable and replicated store byte.
module exemem_lsu_lane #(
   parameter int NUM_LANES = 4,
   parameter int OFF_W     = 2,
   parameter int LANE      = 0
) (
   input  logic [1:0]                 size,
   input  logic [OFF_W-1:0]           off,
   input  logic [NUM_LANES-1:0][7:0]  wdata,
   output logic                       strb,
   output logic [7:0]                 wbyte
);
   localparam logic [OFF_W-1:0] IDX = OFF_W'(LANE);

   logic [OFF_W-1:0] inner;

   // Lane is enabled when it sits in the same size-aligned block as the
   // address; it carries the source byte at its position inside that block.
   always_comb begin
      inner = ~({OFF_W{1'b1}} << size);
      strb  = ((IDX ^ off) & ~inner) == '0;
      wbyte = wdata[IDX & inner];
   end
endmodule

module exemem_lsu_reg #(
   parameter int                     DATA_W      = 32,
   parameter int                     ADDR_W      = 32,
   parameter int                     PAYLOAD_W   = 128,
   parameter logic [PAYLOAD_W-1:0]   PAYLOAD_NOP = '0,
   parameter logic [ADDR_W-1:0]      ADDR_MASK   = 'h1fffffff
) (
   input  logic                   cpu_clk_50M,
   input  logic                   cpu_rst,
   input  logic                   flush,
   input  logic                   exe_stall,
   input  logic                   mem_stall,
   input  logic [PAYLOAD_W-1:0]   exe_payload,
   input  logic [1:0]             exe_mem_op,
   input  logic [1:0]             exe_size,
   input  logic                   exe_signed,
   input  logic [ADDR_W-1:0]      exe_addr,
   input  logic [DATA_W-1:0]      exe_wdata,
   output logic [PAYLOAD_W-1:0]   mem_payload,
   output logic [DATA_W-1:0]      mem_ld_data,
   output logic                   mem_adel,
   output logic                   mem_ades,
   output logic                   stallreq_mem,
   exemem_lsu_reg_if.master       bus
);
   localparam int NUM_LANES = DATA_W / 8;
   localparam int OFF_W     = $clog2(NUM_LANES);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

   // Everything the in-flight transaction needs, frozen at launch so a later
   // capture cannot disturb the bus fields or the load extraction.
   typedef struct packed {
      logic                   wr;
      logic                   sgn;
      logic [1:0]             size;
      logic [OFF_W-1:0]       off;
      logic [ADDR_W-1:0]      addr;
      logic [DATA_W-1:0]      wdata;
      logic [NUM_LANES-1:0]   wstrb;
   } txn_t;

   state_t                           state, nxt;
   txn_t                             txn_q;
   logic                             is_ld, is_st, misal, size_bad;
   logic                             capture, bubble, launch;
   logic [OFF_W-1:0]                 amask;
   logic [NUM_LANES-1:0]             lane_strb;
   logic [NUM_LANES-1:0][7:0]        lane_wbyte;
   logic [DATA_W-1:0]                ld_shift, ld_keep, ld_top, ld_ext;
   int                               ld_bits;

   // Decode the EXE request: op class, alignment, and register update mode.
   always_comb begin
      is_ld    = exe_mem_op == 2'b01;
      is_st    = exe_mem_op == 2'b10;
      // A dword on a 32-bit bus cannot be served; report it as an address error.
      size_bad = (exe_size == 2'd3) && (DATA_W == 32);
      amask    = ~({OFF_W{1'b1}} << exe_size);
      misal    = (|(exe_addr[OFF_W-1:0] & amask)) | size_bad;
      capture  = !flush && !exe_stall;
      bubble   = !flush && exe_stall && !mem_stall;
      launch   = capture && (is_ld || is_st) && !misal && (state == S_IDLE);
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      exemem_lsu_lane #(
         .NUM_LANES (NUM_LANES),
         .OFF_W     (OFF_W),
         .LANE      (i)
      ) u_lane (
         .size  (exe_size),
         .off   (exe_addr[OFF_W-1:0]),
         .wdata (exe_wdata),
         .strb  (lane_strb[i]),
         .wbyte (lane_wbyte[i])
      );
   end

   // FSM state register.
   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) state <= S_IDLE;
      else         state <= nxt;
   end

   // FSM next state; a flush after addr_ok must still wait out data_ok.
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:  if (launch) nxt = S_REQ;
         S_REQ: begin
            if (bus.data_addr_ok) nxt = flush ? S_DRAIN : S_WAIT;
            else if (flush)       nxt = S_IDLE;
         end
         S_WAIT: begin
            if (bus.data_data_ok) nxt = S_IDLE;
            else if (flush)       nxt = S_DRAIN;
         end
         S_DRAIN: if (bus.data_data_ok) nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   // FSM outputs: request only in REQ, stall while anything is outstanding.
   always_comb begin
      bus.data_req = state == S_REQ;
      stallreq_mem = state != S_IDLE;
   end

   // Pipeline register: reset > flush > bubble > capture > hold.
   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         mem_payload <= PAYLOAD_NOP;
         mem_adel    <= 1'b0;
         mem_ades    <= 1'b0;
      end else if (flush || bubble) begin
         mem_payload <= PAYLOAD_NOP;
         mem_adel    <= 1'b0;
         mem_ades    <= 1'b0;
      end else if (capture) begin
         mem_payload <= exe_payload;
         mem_adel    <= is_ld && misal;
         mem_ades    <= is_st && misal;
      end
   end

   // Freeze the transaction fields on launch.
   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         txn_q <= '0;
      end else if (launch) begin
         txn_q.wr    <= is_st;
         txn_q.sgn   <= exe_signed;
         txn_q.size  <= exe_size;
         txn_q.off   <= exe_addr[OFF_W-1:0];
         txn_q.addr  <= exe_addr & ADDR_MASK;
         txn_q.wdata <= lane_wbyte;
         txn_q.wstrb <= lane_strb;
      end
   end

   // Load extraction: shift the addressed bytes down, then zero/sign extend.
   always_comb begin
      ld_shift = bus.data_rdata >> {txn_q.off, 3'b000};
      ld_bits  = 8 << txn_q.size;
      ld_keep  = '1;
      ld_top   = '0;
      ld_ext   = ld_shift;
      if (ld_bits < DATA_W) begin
         ld_keep = ~({DATA_W{1'b1}} << ld_bits);
         ld_top  = ld_keep & ~(ld_keep >> 1);
         ld_ext  = (ld_shift & ld_keep) |
                   ((txn_q.sgn && |(ld_shift & ld_top)) ? ~ld_keep : '0);
      end
   end

   // Load result updates only on a clean completion; drained data is dropped.
   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst)
         mem_ld_data <= '0;
      else if (state == S_WAIT && bus.data_data_ok && !flush && !txn_q.wr)
         mem_ld_data <= ld_ext;
   end

   assign bus.data_wr    = txn_q.wr;
   assign bus.data_size  = txn_q.size;
   assign bus.data_addr  = txn_q.addr;
   assign bus.data_wdata = txn_q.wdata;
   assign bus.data_wstrb = txn_q.wstrb;
endmodule

// File: tb/tb_exemem_lsu_reg.sv
// Scoreboard bench for exemem_lsu_reg: expected load results are queued at
// issue and compared when the transfer completes.
module tb_exemem_lsu_reg;
   localparam int          DW   = 32;
   localparam int          AW   = 32;
   localparam int          PW   = 128;
   localparam logic [31:0] MASK = 32'h1fff_ffff;

   logic cpu_clk_50M = 1'b0;
   always #5 cpu_clk_50M = ~cpu_clk_50M;

   logic            cpu_rst, flush, exe_stall, mem_stall, exe_signed;
   logic [PW-1:0]   exe_payload, mem_payload;
   logic [1:0]      exe_mem_op, exe_size;
   logic [AW-1:0]   exe_addr;
   logic [DW-1:0]   exe_wdata, mem_ld_data;
   logic            mem_adel, mem_ades, stallreq_mem;

   exemem_lsu_reg_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   exemem_lsu_reg #(.DATA_W(DW), .ADDR_W(AW), .PAYLOAD_W(PW)) dut (
      .cpu_clk_50M  (cpu_clk_50M),
      .cpu_rst      (cpu_rst),
      .flush        (flush),
      .exe_stall    (exe_stall),
      .mem_stall    (mem_stall),
      .exe_payload  (exe_payload),
      .exe_mem_op   (exe_mem_op),
      .exe_size     (exe_size),
      .exe_signed   (exe_signed),
      .exe_addr     (exe_addr),
      .exe_wdata    (exe_wdata),
      .mem_payload  (mem_payload),
      .mem_ld_data  (mem_ld_data),
      .mem_adel     (mem_adel),
      .mem_ades     (mem_ades),
      .stallreq_mem (stallreq_mem),
      .bus          (bus)
   );

   int          n_chk = 0;
   int          n_pass = 0;
   logic [31:0] sb[$];
   logic [31:0] last_ld = '0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] exp_ld(input logic [31:0] rd, input logic [31:0] a,
                                          input logic [1:0] sz, input logic sg);
      logic [31:0] s;
      s = rd >> (8 * a[1:0]);
      case (sz)
         2'd0:    return {{24{sg & s[7]}}, s[7:0]};
         2'd1:    return {{16{sg & s[15]}}, s[15:0]};
         default: return s;
      endcase
   endfunction

   function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [31:0] a);
      case (sz)
         2'd0:    return 4'b0001 << a[1:0];
         2'd1:    return 4'b0011 << a[1:0];
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] wd);
      case (sz)
         2'd0:    return {4{wd[7:0]}};
         2'd1:    return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   task automatic tick();
      @(negedge cpu_clk_50M);
   endtask

   // One capture cycle, then hold the pipeline (both stages stalled).
   task automatic issue(input logic [1:0] op, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [127:0] pl);
      tick();
      exe_mem_op = op; exe_size = sz; exe_signed = sg; exe_addr = a;
      exe_wdata = wd; exe_payload = pl; exe_stall = 0; mem_stall = 0;
      tick();
      exe_stall = 1; mem_stall = 1; exe_mem_op = 2'b00;
   endtask

   // Slave: addr_ok while req is seen, data_ok `gap` cycles after acceptance.
   task automatic drive_bus(input int gap, input logic [31:0] rd, output int cyc);
      int g;
      cyc = 0; g = 0;
      for (int c = 0; c < 40; c++) begin
         if (!stallreq_mem) break;
         cyc++;
         if (bus.data_req) begin
            bus.data_addr_ok = 1; bus.data_data_ok = 0;
         end else begin
            bus.data_addr_ok = 0; g++;
            bus.data_data_ok = (g >= gap);
            bus.data_rdata   = (g >= gap) ? rd : 32'h0;
         end
         tick();
      end
      bus.data_addr_ok = 0; bus.data_data_ok = 0;
      chk("bus_done", stallreq_mem, 0);
   endtask

   task automatic do_load(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                          input logic [31:0] rd, input int gap, input int exp_cyc);
      logic [31:0] e;
      int          cyc;
      sb.push_back(exp_ld(rd, a, sz, sg));
      issue(2'b01, sz, sg, a, 32'h0, {96'h0, a});
      chk("ld_req", bus.data_req, 1);
      chk("ld_addr", bus.data_addr, a & MASK);
      chk("ld_wr", bus.data_wr, 0);
      chk("ld_size", bus.data_size, sz);
      chk("ld_payload", mem_payload, {96'h0, a});
      drive_bus(gap, rd, cyc);
      chk("ld_stall_cyc", cyc, exp_cyc);
      e = sb.pop_front();
      chk("ld_data", mem_ld_data, e);
      last_ld = e;
   endtask

   task automatic do_store(input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input int gap);
      int cyc;
      issue(2'b10, sz, 1'b0, a, wd, 128'h5);
      chk("st_req", bus.data_req, 1);
      chk("st_wr", bus.data_wr, 1);
      chk("st_strb", bus.data_wstrb, exp_strb(sz, a));
      chk("st_wdata", bus.data_wdata, exp_wd(sz, wd));
      chk("st_addr", bus.data_addr, a & MASK);
      drive_bus(gap, 32'hdead_beef, cyc);
      chk("st_stall_cyc", cyc, gap + 1);
      chk("st_ld_keep", mem_ld_data, last_ld);
   endtask

   initial begin
      int  cyc;
      bit  saw_req;
      cpu_rst = 1; flush = 0; exe_stall = 1; mem_stall = 1; exe_signed = 0;
      exe_payload = '0; exe_mem_op = 0; exe_size = 0; exe_addr = 0; exe_wdata = 0;
      bus.data_rdata = 0; bus.data_addr_ok = 0; bus.data_data_ok = 0;
      tick(); tick();
      cpu_rst = 0;
      tick();
      chk("rst_req", bus.data_req, 0);
      chk("rst_stall", stallreq_mem, 0);
      chk("rst_payload", mem_payload, 0);
      chk("rst_ld", mem_ld_data, 0);
      chk("rst_ad", {mem_adel, mem_ades}, 0);
      chk("rst_strb", bus.data_wstrb, 0);

      // Non-memory op: capture, hold, bubble.
      issue(2'b00, 2'd2, 1'b0, 32'h40, 32'h0, 128'hc0ffee);
      chk("nop_payload", mem_payload, 128'hc0ffee);
      chk("nop_req", bus.data_req, 0);
      tick();
      chk("hold_payload", mem_payload, 128'hc0ffee);
      mem_stall = 0; tick(); mem_stall = 1;
      chk("bubble_payload", mem_payload, 0);
      issue(2'b11, 2'd2, 1'b0, 32'h40, 32'h0, 128'h1);
      chk("rsvd_req", bus.data_req, 0);

      // Loads of several sizes/offsets.
      do_load(2'd2, 1'b0, 32'ha000_1000, 32'h8765_4321, 2, 3);
      do_load(2'd0, 1'b1, 32'h0000_2003, 32'h8012_3456, 1, 2);
      do_load(2'd0, 1'b0, 32'h0000_2003, 32'h8012_3456, 1, 2);
      do_load(2'd1, 1'b1, 32'h0000_2002, 32'h9abc_0000, 2, 3);
      do_load(2'd1, 1'b0, 32'h0000_2000, 32'h1234_f00d, 1, 2);

      // Stores.
      do_store(2'd1, 32'h0000_3002, 32'h0000_beef, 1);
      do_store(2'd0, 32'h0000_3001, 32'h0000_005a, 2);
      do_store(2'd2, 32'h0000_3004, 32'h0102_0304, 1);

      // Misaligned: flagged, no request.
      issue(2'b01, 2'd2, 1'b0, 32'h0000_0102, 32'h0, 128'h7);
      chk("adel", mem_adel, 1);
      chk("adel_ades", mem_ades, 0);
      saw_req = 0;
      for (int i = 0; i < 3; i++) begin saw_req |= bus.data_req | stallreq_mem; tick(); end
      chk("adel_noreq", saw_req, 0);
      issue(2'b10, 2'd2, 1'b0, 32'h0000_0102, 32'h0, 128'h8);
      chk("ades", mem_ades, 1);
      chk("ades_adel", mem_adel, 0);
      chk("ades_noreq", bus.data_req, 0);

      // Flush in WAIT, data_ok 4 cycles later: drain, result discarded.
      issue(2'b01, 2'd2, 1'b0, 32'h0000_0200, 32'h0, 128'h9);
      bus.data_addr_ok = 1; tick(); bus.data_addr_ok = 0;
      flush = 1; tick(); flush = 0;
      chk("drain_stall", stallreq_mem, 1);
      chk("drain_payload", mem_payload, 0);
      saw_req = 0;
      for (int i = 0; i < 3; i++) begin saw_req |= bus.data_req | !stallreq_mem; tick(); end
      chk("drain_noreq_held", saw_req, 0);
      bus.data_data_ok = 1; bus.data_rdata = 32'hffff_ffff; tick(); bus.data_data_ok = 0;
      chk("drain_release", stallreq_mem, 0);
      chk("drain_ld_keep", mem_ld_data, last_ld);

      // Flush coincident with addr_ok in REQ -> drain.
      issue(2'b01, 2'd2, 1'b0, 32'h0000_0300, 32'h0, 128'ha);
      bus.data_addr_ok = 1; flush = 1; tick(); bus.data_addr_ok = 0; flush = 0;
      chk("fa_stall", stallreq_mem, 1);
      chk("fa_req", bus.data_req, 0);
      bus.data_data_ok = 1; bus.data_rdata = 32'h1111_1111; tick(); bus.data_data_ok = 0;
      chk("fa_release", stallreq_mem, 0);
      chk("fa_ld_keep", mem_ld_data, last_ld);

      // Flush in REQ without addr_ok -> request withdrawn.
      issue(2'b01, 2'd2, 1'b0, 32'h0000_0304, 32'h0, 128'hb);
      flush = 1; tick(); flush = 0;
      chk("wd_req", bus.data_req, 0);
      chk("wd_stall", stallreq_mem, 0);

      // Reset mid-WAIT.
      issue(2'b01, 2'd2, 1'b0, 32'h0000_0abc, 32'h0, 128'hc);
      bus.data_addr_ok = 1; tick(); bus.data_addr_ok = 0;
      cpu_rst = 1; tick(); cpu_rst = 0;
      chk("mrst_stall", stallreq_mem, 0);
      chk("mrst_req", bus.data_req, 0);
      chk("mrst_ld", mem_ld_data, 0);
      chk("mrst_addr", bus.data_addr, 0);
      chk("mrst_payload", mem_payload, 0);
      last_ld = 0;
      bus.data_data_ok = 1; bus.data_rdata = 32'h2222_2222; tick(); bus.data_data_ok = 0;
      chk("stray_ok_ld", mem_ld_data, 0);
      chk("stray_ok_stall", stallreq_mem, 0);
      do_load(2'd2, 1'b0, 32'h0000_0010, 32'hcafe_f00d, 1, 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
